// File: rtl/sram_burst_ctrl_if.sv
// Command, write-stream, read-stream and RAM-pin bundle for sram_burst_ctrl.
// master = controller side, slave = datapath/RAM environment side.
interface sram_burst_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [4:0] req_addr;
  logic [2:0] req_len;
  logic       wr_valid;
  logic       wr_ready;
  logic [3:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [3:0] rd_data;
  logic       done;
  logic [4:0] mem_addr;
  logic [3:0] mem_din;
  logic       mem_we;
  logic [3:0] mem_dout;

  modport master (
    input  req_valid, req_we, req_addr, req_len, wr_valid, wr_data, rd_ready, mem_dout,
    output req_ready, wr_ready, rd_valid, rd_data, done, mem_addr, mem_din, mem_we
  );

  modport slave (
    output req_valid, req_we, req_addr, req_len, wr_valid, wr_data, rd_ready, mem_dout,
    input  req_ready, wr_ready, rd_valid, rd_data, done, mem_addr, mem_din, mem_we
  );
endinterface

// File: rtl/sram_burst_ctrl.sv
// Burst sequencer for a 32x4 synchronous SRAM: 1 write beat/cycle, 1 read beat/3 cycles.
// Optional power-up clear sweep of the RAM when SRAM_BURST_CTRL_CLEAR_EN is defined.
module sram_burst_ctrl (
  input  logic               i_clk,
  input  logic               i_rst,
  sram_burst_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    INIT, IDLE, WR, RD_ISSUE, RD_CAPT, RD_HOLD
  } state_t;

  state_t     r_state;
  logic [4:0] r_cur_addr;
  logic [2:0] r_beats_left;
  logic       r_rd_valid;
  logic [3:0] r_rd_data;
  logic       r_done;

  logic       w_wr_beat;
  logic       w_sweep_we;

  // Write pins are driven in the WR cycle itself so the RAM captures the beat on its closing edge.
  assign w_wr_beat = (r_state == WR) && bus.wr_valid;

`ifdef SRAM_BURST_CTRL_CLEAR_EN
  assign w_sweep_we = (r_state == INIT) && !i_rst;
`else
  assign w_sweep_we = 1'b0;
`endif

  assign bus.req_ready = (r_state == IDLE);
  assign bus.wr_ready  = w_wr_beat;
  assign bus.mem_we    = w_wr_beat | w_sweep_we;
  assign bus.mem_addr  = r_cur_addr;
  assign bus.mem_din   = w_wr_beat ? bus.wr_data : 4'd0;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = r_rd_data;
  assign bus.done      = r_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= INIT;
      r_cur_addr   <= 5'd0;
      r_beats_left <= 3'd0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= 4'd0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        INIT: begin
`ifdef SRAM_BURST_CTRL_CLEAR_EN
          if (r_cur_addr == 5'd31) begin
            r_cur_addr <= 5'd0;
            r_state    <= IDLE;
          end else begin
            r_cur_addr <= r_cur_addr + 5'd1;
          end
`else
          r_state <= IDLE;
`endif
        end
        IDLE: begin
          if (bus.req_valid) begin
            r_cur_addr   <= bus.req_addr;
            r_beats_left <= bus.req_len;
            r_state      <= bus.req_we ? WR : RD_ISSUE;
          end
        end
        WR: begin
          if (bus.wr_valid) begin
            r_cur_addr <= r_cur_addr + 5'd1;
            if (r_beats_left == 3'd0) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_beats_left <= r_beats_left - 3'd1;
            end
          end
        end
        RD_ISSUE: r_state <= RD_CAPT;
        RD_CAPT: begin
          r_rd_data  <= bus.mem_dout;
          r_rd_valid <= 1'b1;
          r_state    <= RD_HOLD;
        end
        RD_HOLD: begin
          if (bus.rd_ready) begin
            r_rd_valid <= 1'b0;
            r_cur_addr <= r_cur_addr + 5'd1;
            if (r_beats_left == 3'd0) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_beats_left <= r_beats_left - 3'd1;
              r_state      <= RD_ISSUE;
            end
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl: directed burst table, reset corners, then random bursts vs a memory model.
module tb_sram_burst_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_burst_ctrl_if bus ();

  sram_burst_ctrl dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  // RAM behaviour: synchronous write, registered read data.
  logic [3:0] ram [32] = '{default: 4'd0};
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= ram[bus.mem_addr];
  end

  logic [3:0] ref_mem [32] = '{default: 4'd0};
  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    bit          we;
    logic [4:0]  addr;
    logic [2:0]  len;
    logic [31:0] dat;   // nibble i = write data or expected read data of beat i
    int          stall;
    int          hold;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] ref_exp(input logic [4:0] a, input logic [2:0] l);
    logic [31:0] r;
    logic [4:0]  ai;
    r = 32'd0;
    for (int i = 0; i <= int'(l); i++) begin
      ai = a + 5'(i);
      r[4*i +: 4] = ref_mem[ai];
    end
    return r;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    chk({tag, "_wr_ready"},  32'(bus.wr_ready), 0);
    chk({tag, "_rd_valid"},  32'(bus.rd_valid), 0);
    chk({tag, "_done"},      32'(bus.done), 0);
    chk({tag, "_mem_we"},    32'(bus.mem_we), 0);
    chk({tag, "_rd_data"},   32'(bus.rd_data), 0);
    chk({tag, "_mem_addr"},  32'(bus.mem_addr), 0);
    chk({tag, "_mem_din"},   32'(bus.mem_din), 0);
  endtask

  // Called with rst high at posedge+1; releases reset and measures cycles until req_ready.
  task automatic release_reset();
    int cnt;
    int exp_cycles;
`ifdef SRAM_BURST_CTRL_CLEAR_EN
    exp_cycles = 32;
`else
    exp_cycles = 1;
`endif
    chk_reset_outputs("rst");
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.req_ready) break;
      cnt++;
    end
    chk("startup_cycles", 32'(cnt), 32'(exp_cycles));
`ifdef SRAM_BURST_CTRL_CLEAR_EN
    foreach (ref_mem[k]) ref_mem[k] = 4'd0;
`endif
    @(posedge clk); #1;
  endtask

  task automatic issue(input bit we, input logic [4:0] a, input logic [2:0] l, output bit ok);
    ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_len   = l;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      chk("req_accept_timeout", 0, 1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [2:0] l, input logic [31:0] d, input int stall_beat);
    bit ok;
    logic [4:0] ai;
    issue(1'b1, a, l, ok);
    if (!ok) return;
    for (int i = 0; i <= int'(l); i++) begin
      ai = a + 5'(i);
      if (i == stall_beat) begin
        bus.wr_valid = 1'b0;
        for (int s = 0; s < 2; s++) begin
          @(negedge clk);
          chk("wr_stall_mem_we", 32'(bus.mem_we), 0);
          chk("wr_stall_wr_ready", 32'(bus.wr_ready), 0);
          @(posedge clk); #1;
        end
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = d[4*i +: 4];
      @(negedge clk);
      chk("wr_mem_we", 32'(bus.mem_we), 1);
      chk("wr_mem_addr", 32'(bus.mem_addr), 32'(ai));
      chk("wr_mem_din", 32'(bus.mem_din), 32'(d[4*i +: 4]));
      chk("wr_ready", 32'(bus.wr_ready), 1);
      chk("wr_busy_req_ready", 32'(bus.req_ready), 0);
      chk("wr_early_done", 32'(bus.done), 0);
      @(posedge clk); #1;
      ref_mem[ai] = d[4*i +: 4];
    end
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("wr_done", 32'(bus.done), 1);
    chk("wr_idle_req_ready", 32'(bus.req_ready), 1);
    chk("wr_after_mem_we", 32'(bus.mem_we), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr_done_single", 32'(bus.done), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [4:0] a, input logic [2:0] l, input logic [31:0] exp, input int hold);
    bit ok;
    logic [4:0] ai;
    bus.rd_ready = 1'b1;
    issue(1'b0, a, l, ok);
    if (!ok) return;
    for (int i = 0; i <= int'(l); i++) begin
      ai = a + 5'(i);
      @(negedge clk);
      chk("rd_issue_mem_we", 32'(bus.mem_we), 0);
      chk("rd_issue_addr", 32'(bus.mem_addr), 32'(ai));
      chk("rd_issue_valid", 32'(bus.rd_valid), 0);
      chk("rd_busy_req_ready", 32'(bus.req_ready), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rd_capt_valid", 32'(bus.rd_valid), 0);
      @(posedge clk); #1;
      bus.rd_ready = (hold == 0);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("rd_hold_valid", 32'(bus.rd_valid), 1);
        chk("rd_hold_data", 32'(bus.rd_data), 32'(exp[4*i +: 4]));
        chk("rd_hold_addr", 32'(bus.mem_addr), 32'(ai));
        @(posedge clk); #1;
      end
      bus.rd_ready = 1'b1;
      @(negedge clk);
      chk("rd_valid", 32'(bus.rd_valid), 1);
      chk("rd_data", 32'(bus.rd_data), 32'(exp[4*i +: 4]));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rd_done", 32'(bus.done), 1);
    chk("rd_after_valid", 32'(bus.rd_valid), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    bit ok;
    logic [4:0]  ra;
    logic [2:0]  rl;
    logic [31:0] rd;

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 5'd0;
    bus.req_len   = 3'd0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = 4'd0;
    bus.rd_ready  = 1'b1;

    vecs[0] = '{1'b1, 5'd5,  3'd0, 32'h0000_000A, -1, 0};
    vecs[1] = '{1'b1, 5'd3,  3'd3, 32'h0000_DCBA, -1, 0};
    vecs[2] = '{1'b0, 5'd3,  3'd3, 32'h0000_DCBA, -1, 0};
    vecs[3] = '{1'b1, 5'd30, 3'd3, 32'h0000_4321,  2, 0};
    vecs[4] = '{1'b0, 5'd0,  3'd0, 32'h0000_0003, -1, 0};
    vecs[5] = '{1'b0, 5'd30, 3'd3, 32'h0000_4321, -1, 4};
    vecs[6] = '{1'b0, 5'd5,  3'd0, 32'h0000_000C, -1, 1};

    repeat (2) @(posedge clk);
    #1;
    release_reset();

`ifdef SRAM_BURST_CTRL_CLEAR_EN
    for (int b = 0; b < 4; b++) do_read(5'(8 * b), 3'd7, 32'd0, 0);
`endif

    foreach (vecs[v]) begin
      if (vecs[v].we) do_write(vecs[v].addr, vecs[v].len, vecs[v].dat, vecs[v].stall);
      else            do_read(vecs[v].addr, vecs[v].len, vecs[v].dat, vecs[v].hold);
    end

    // Reset during beat 2 of an 8-beat write: beats 0 and 1 persist, beat 2 never lands.
    rd = ref_exp(5'd8, 3'd2);
    issue(1'b1, 5'd8, 3'd7, ok);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 4'h5;
    @(negedge clk); @(posedge clk); #1;
    bus.wr_data  = 4'h6;
    @(negedge clk); @(posedge clk); #1;
    bus.wr_data  = 4'h7;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    bus.wr_valid = 1'b0;
    ref_mem[8] = 4'h5;
    ref_mem[9] = 4'h6;
    @(posedge clk); #1;
    release_reset();
    do_read(5'd8, 3'd2, ref_exp(5'd8, 3'd2), 0);
`ifndef SRAM_BURST_CTRL_CLEAR_EN
    chk("midrst_beat2_untouched", 32'(ref_mem[10]), 32'(rd[11:8]));
`endif

    for (int r = 0; r < 16; r++) begin
      ra = 5'($urandom_range(0, 31));
      rl = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        rd = $urandom;
        do_write(ra, rl, rd, int'($urandom_range(0, 9)));
      end else begin
        do_read(ra, rl, ref_exp(ra, rl), int'($urandom_range(0, 2)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
